// File: rtl/lfgm_pkg.sv
// Shared lifegame constants and the 5-bit phase code consumed by the line generator
// and the judge cells.
package lfgm_pkg;

    localparam int LFGM_ROW_W  = 82;
    localparam int LFGM_MEM_W  = 108;
    localparam int LFGM_RD_LAT = 2;
    localparam int LFGM_CHK_N  = 8;

    typedef enum logic [4:0] {
        PH_PRE_READ_1 = 5'd0,
        PH_READ       = 5'd1,
        PH_SHIFTIN    = 5'd5,
        PH_CHK_UL     = 5'd6,
        PH_CHK_UM     = 5'd7,
        PH_CHK_UR     = 5'd8,
        PH_CHK_ML     = 5'd9,
        PH_CHK_MR     = 5'd10,
        PH_CHK_LL     = 5'd11,
        PH_CHK_LM     = 5'd12,
        PH_CHK_LR     = 5'd13,
        PH_JDG        = 5'd14,
        PH_DLT        = 5'd15,
        PH_WRITE      = 5'd16,
        PH_WAIT       = 5'd17
    } lfgm_phase_e;

endpackage

// File: rtl/lfgm_wb_buf.sv
// Write-back buffer: holds one finished row and its address so that the row is
// written to memory one row late (on the next capture, or on flush).
module lfgm_wb_buf
    import lfgm_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  capture,
    input  logic                  flush,
    input  logic [ADDR_W-1:0]     row,
    input  logic [LFGM_ROW_W-1:0] row_data,
    output logic                  wr,
    output logic [ADDR_W-1:0]     waddr,
    output logic [LFGM_MEM_W-1:0] wdata
);

    logic [LFGM_ROW_W-1:0] pend_q;
    logic [ADDR_W-1:0]     paddr_q;
    logic                  pend_vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= '0;
            paddr_q    <= '0;
            pend_vld_q <= 1'b0;
        end else if (capture) begin
            pend_q     <= row_data;
            paddr_q    <= row;
            pend_vld_q <= 1'b1;
        end else if (flush) begin
            pend_vld_q <= 1'b0;
        end
    end

    // The first capture of a generation has nothing pending, so it writes nothing.
    assign wr    = (capture | flush) & pend_vld_q;
    assign waddr = wr ? paddr_q : '0;
    assign wdata = wr ? {{(LFGM_MEM_W-LFGM_ROW_W){1'b0}}, pend_q} : '0;

endmodule

// File: rtl/lfgm_row_seq.sv
// Row sequencer / write-back controller for one lifegame generation.
// Optional generation counter enabled by defining LFGM_SEQ_GEN_CNT_EN.
//
// state    | meaning
// S_WAIT   | idle, waiting for start
// S_PRE    | prime the read pipe with row 0
// S_READ   | read row r+1 (wall row for the last r)
// S_SHIFT  | read-latency dwell while data shifts into the generator
// S_CHK    | eight neighbour check phases, wcf high
// S_JDG    | judge
// S_DLT    | delta
// S_WRITE  | capture result, write back row r-1
// S_FLUSH  | write back the final pending row
// S_DONE   | done pulse
module lfgm_row_seq
    import lfgm_pkg::*;
#(
    parameter int ROWS   = 60,
    parameter int ADDR_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4:0]            state,
    output logic                  wcf,
    output logic                  mem_rd,
    output logic [ADDR_W-1:0]     mem_raddr,
    output logic                  mem_wr,
    output logic [ADDR_W-1:0]     mem_waddr,
    output logic [LFGM_MEM_W-1:0] mem_wdata,
    input  logic [LFGM_ROW_W-1:0] next_cell_dt,
    output logic [15:0]           gen_cnt
);

    typedef enum logic [3:0] {
        S_WAIT, S_PRE, S_READ, S_SHIFT, S_CHK, S_JDG, S_DLT, S_WRITE, S_FLUSH, S_DONE
    } seq_st_e;

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

    seq_st_e          st_q, st_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [2:0]       dwell_q, dwell_d;
    lfgm_phase_e      phase;
    logic             capture, flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= S_WAIT;
            row_q   <= '0;
            dwell_q <= '0;
        end else begin
            st_q    <= st_d;
            row_q   <= row_d;
            dwell_q <= dwell_d;
        end
    end

    always_comb begin
        st_d      = st_q;
        row_d     = row_q;
        dwell_d   = dwell_q;
        phase     = PH_WAIT;
        wcf       = 1'b0;
        mem_rd    = 1'b0;
        mem_raddr = '0;
        capture   = 1'b0;
        flush     = 1'b0;
        done      = 1'b0;
        case (st_q)
            S_WAIT: begin
                if (start) st_d = S_PRE;
            end
            S_PRE: begin
                phase  = PH_PRE_READ_1;
                mem_rd = 1'b1;
                row_d  = '0;
                st_d   = S_READ;
            end
            S_READ: begin
                phase     = PH_READ;
                mem_rd    = 1'b1;
                mem_raddr = row_q + 1'b1;
                dwell_d   = 3'(LFGM_RD_LAT - 1);
                st_d      = S_SHIFT;
            end
            S_SHIFT: begin
                phase = PH_SHIFTIN;
                if (dwell_q == '0) begin
                    dwell_d = 3'(LFGM_CHK_N - 1);
                    st_d    = S_CHK;
                end else begin
                    dwell_d = dwell_q - 1'b1;
                end
            end
            S_CHK: begin
                // Dwell counts 7..0, mapping onto CHK_UL..CHK_LR.
                phase = lfgm_phase_e'(5'(PH_CHK_LR) - {2'b00, dwell_q});
                wcf   = 1'b1;
                if (dwell_q == '0) st_d = S_JDG;
                else dwell_d = dwell_q - 1'b1;
            end
            S_JDG: begin
                phase = PH_JDG;
                st_d  = S_DLT;
            end
            S_DLT: begin
                phase = PH_DLT;
                st_d  = S_WRITE;
            end
            S_WRITE: begin
                phase   = PH_WRITE;
                capture = 1'b1;
                row_d   = row_q + 1'b1;
                st_d    = (row_q == LAST_ROW) ? S_FLUSH : S_READ;
            end
            S_FLUSH: begin
                phase = PH_WRITE;
                flush = 1'b1;
                row_d = '0;
                st_d  = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                st_d = S_WAIT;
            end
            default: st_d = S_WAIT;
        endcase
    end

    assign state = phase;
    assign busy  = (st_q != S_WAIT);

    lfgm_wb_buf #(.ADDR_W(ADDR_W)) u_wb_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .capture  (capture),
        .flush    (flush),
        .row      (row_q),
        .row_data (next_cell_dt),
        .wr       (mem_wr),
        .waddr    (mem_waddr),
        .wdata    (mem_wdata)
    );

`ifdef LFGM_SEQ_GEN_CNT_EN
    logic [15:0] gen_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) gen_cnt_q <= '0;
        else if (st_q == S_DONE) gen_cnt_q <= gen_cnt_q + 16'd1;
    end

    assign gen_cnt = gen_cnt_q;
`else
    assign gen_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_lfgm_row_seq.sv
// Directed bench for lfgm_row_seq: memory model plus a behavioural line generator.
module tb_lfgm_row_seq;

    logic         clk = 1'b0;
    logic         rst_n, start;
    logic         busy, done, wcf, mem_rd, mem_wr;
    logic [4:0]   state;
    logic [5:0]   mem_raddr, mem_waddr;
    logic [107:0] mem_wdata;
    logic [81:0]  next_cell_dt = '1;
    logic [15:0]  gen_cnt;

    lfgm_row_seq #(.ROWS(60), .ADDR_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .state(state), .wcf(wcf), .mem_rd(mem_rd), .mem_raddr(mem_raddr),
        .mem_wr(mem_wr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .next_cell_dt(next_cell_dt), .gen_cnt(gen_cnt)
    );

    always #5 clk = ~clk;

    logic [81:0] mem [64];
    logic [81:0] rdv [64];
    int rd_cyc [64];
    int wr_cyc [64];
    int wr_log [64];
    int n_wr, n_rd, n_done, done_rel, n_ovl, n_wcf_bad, n_hi_bad, n_addr_bad;
    int cur_row = 0, c0 = 0, cyc = 0, total_done = 0;
    int n_tests = 0, n_fail = 0;

    always @(posedge clk) cyc++;

    function automatic logic [81:0] life(input int r);
        logic [81:0] up, mid, dn, res;
        int n, cc;
        up  = (r > 0) ? rdv[r-1] : '0;
        mid = rdv[r];
        dn  = rdv[r+1];
        res = '0;
        for (int c = 0; c < 82; c++) begin
            n = 0;
            for (int dc = -1; dc <= 1; dc++) begin
                cc = c + dc;
                if (cc >= 0 && cc < 82) begin
                    n += int'(up[cc]) + int'(dn[cc]);
                    if (dc != 0) n += int'(mid[cc]);
                end
            end
            res[c] = (n == 3) || (mid[c] && n == 2);
        end
        return res;
    endfunction

    // Memory model, strobe logger and behavioural generator.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd) begin
                rd_cyc[mem_raddr] = cyc - c0;
                rdv[mem_raddr] = mem[mem_raddr];
                if (mem_raddr >= 1) cur_row = int'(mem_raddr) - 1;
                n_rd++;
            end
            if (mem_wr) begin
                wr_cyc[mem_waddr] = cyc - c0;
                if (n_wr < 64) wr_log[n_wr] = int'(mem_waddr);
                if (mem_wdata[107:82] != '0) n_hi_bad++;
                if (mem_waddr >= 6'd60) n_addr_bad++;
                mem[mem_waddr] = mem_wdata[81:0];
                n_wr++;
            end
            if (mem_rd && mem_wr) n_ovl++;
            if (wcf !== (state >= 5'd6 && state <= 5'd13)) n_wcf_bad++;
            if (done) begin
                n_done++;
                total_done++;
                done_rel = cyc - c0;
            end
        end
        next_cell_dt = (state == 5'd16) ? life(cur_row) : '1;
    end

    task automatic clear_logs();
        for (int i = 0; i < 64; i++) begin
            rd_cyc[i] = -1;
            wr_cyc[i] = -1;
            wr_log[i] = -1;
            rdv[i] = '0;
        end
        n_wr = 0; n_rd = 0; n_done = 0; done_rel = -1;
        n_ovl = 0; n_wcf_bad = 0; n_hi_bad = 0; n_addr_bad = 0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = '0;
    endtask

    task automatic launch();
        clear_logs();
        @(posedge clk); #1;
        c0 = cyc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int drel);
        drel = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #1;
            if (n_done > 0) break;
        end
        drel = done_rel;
    endtask

    task automatic run_gen(output int drel);
        launch();
        wait_done(drel);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        clear_mem();
        clear_logs();
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (state !== 5'd17) begin n_fail++; $display("FAIL reset_state got %0d want 17", state); end
        n_tests++;
        if ({busy, done, wcf, mem_rd, mem_wr} !== 5'b0) begin
            n_fail++; $display("FAIL reset_strobes got %b want 00000", {busy, done, wcf, mem_rd, mem_wr});
        end
        n_tests++;
        if (mem_raddr !== 6'd0 || mem_waddr !== 6'd0 || mem_wdata !== 108'd0) begin
            n_fail++; $display("FAIL reset_mem got raddr %0d waddr %0d wdata %h want 0", mem_raddr, mem_waddr, mem_wdata);
        end
        n_tests++;
        if (gen_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_gen_cnt got %0d want 0", gen_cnt); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        total_done = 0;
    endtask

    task automatic test_blinker();
        int d, bad, kk;
        logic [81:0] one;
        clear_mem();
        mem[10][22:20] = 3'b111;
        one = '0;
        one[21] = 1'b1;
        run_gen(d);
        n_tests++;
        if (d !== 843) begin n_fail++; $display("FAIL blinker_done_cycle got %0d want 843", d); end
        n_tests++;
        if (n_wr !== 60) begin n_fail++; $display("FAIL blinker_wr_count got %0d want 60", n_wr); end
        bad = 0;
        for (int i = 0; i < 60; i++) if (wr_log[i] != i) bad++;
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL blinker_waddr_seq got %0d out-of-order want 0", bad); end
        n_tests++;
        if (mem[9] !== one || mem[10] !== one || mem[11] !== one) begin
            n_fail++; $display("FAIL blinker_rows got r9 %h r10 %h r11 %h want %h", mem[9], mem[10], mem[11], one);
        end
        bad = 0;
        for (int i = 0; i < 61; i++) if (i < 9 || i > 11) if (mem[i] != '0) bad++;
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL blinker_other_rows got %0d nonzero want 0", bad); end
        bad = 0;
        for (int k = 0; k < 60; k++) begin
            kk = (k + 2 > 60) ? 60 : k + 2;
            if (rd_cyc[kk] < 0 || wr_cyc[k] <= rd_cyc[kk]) bad++;
        end
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL hazard_order got %0d early writes want 0", bad); end
        n_tests++;
        if (n_rd !== 61) begin n_fail++; $display("FAIL read_count got %0d want 61", n_rd); end
        n_tests++;
        if (n_ovl !== 0 || n_wcf_bad !== 0) begin
            n_fail++; $display("FAIL strobe_rules got rd_wr_overlap %0d wcf_bad %0d want 0 0", n_ovl, n_wcf_bad);
        end
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_done got %b want 1", busy); end
        @(negedge clk); #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || state !== 5'd17) begin
            n_fail++; $display("FAIL after_done got busy %b done %b state %0d want 0 0 17", busy, done, state);
        end
    endtask

    task automatic test_wall();
        int d;
        clear_mem();
        run_gen(d);
        n_tests++;
        if (n_hi_bad !== 0 || n_addr_bad !== 0 || n_wr !== 60) begin
            n_fail++; $display("FAIL wall got hi_bad %0d addr_bad %0d writes %0d want 0 0 60", n_hi_bad, n_addr_bad, n_wr);
        end
        for (int i = 0; i < 61; i++) begin
            if (mem[i] != '0) begin
                n_tests++; n_fail++;
                $display("FAIL wall_row got row %0d = %h want 0", i, mem[i]);
                break;
            end
        end
    endtask

    task automatic test_reset_mid_gen();
        int d;
        launch();
        while (cyc - c0 < 400) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (state !== 5'd17 || busy !== 1'b0 || mem_wr !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset got state %0d busy %b wr %b want 17 0 0", state, busy, mem_wr);
        end
        @(negedge clk); #1;
        n_tests++;
        if (state !== 5'd17 || busy !== 1'b0 || mem_wr !== 1'b0 || gen_cnt !== 16'd0) begin
            n_fail++; $display("FAIL mid_reset_hold got state %0d busy %b wr %b cnt %0d want 17 0 0 0", state, busy, mem_wr, gen_cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        total_done = 0;
        run_gen(d);
        n_tests++;
        if (d !== 843 || n_wr !== 60) begin
            n_fail++; $display("FAIL mid_reset_rerun got done %0d writes %0d want 843 60", d, n_wr);
        end
    endtask

    task automatic test_start_while_busy();
        int d;
        logic [15:0] exp_cnt;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        total_done = 0;
        launch();
        while (cyc - c0 < 100) begin
            @(posedge clk); #1;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(d);
        repeat (900) @(negedge clk);
        #1;
`ifdef LFGM_SEQ_GEN_CNT_EN
        exp_cnt = 16'd1;
`else
        exp_cnt = 16'd0;
`endif
        n_tests++;
        if (d !== 843 || n_done !== 1) begin
            n_fail++; $display("FAIL busy_start got done %0d count %0d want 843 1", d, n_done);
        end
        n_tests++;
        if (gen_cnt !== exp_cnt) begin n_fail++; $display("FAIL busy_gen_cnt got %0d want %0d", gen_cnt, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        int d1, d2;
        run_gen(d1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (busy !== 1'b0 || state !== 5'd17) begin
            n_fail++; $display("FAIL start_in_done got busy %b state %0d want 0 17", busy, state);
        end
        run_gen(d1);
        run_gen(d2);
        n_tests++;
        if (d1 !== 843 || d2 !== 843) begin
            n_fail++; $display("FAIL back_to_back got %0d %0d want 843 843", d1, d2);
        end
    endtask

    task automatic test_gen_cnt();
        int d;
`ifdef LFGM_SEQ_GEN_CNT_EN
        force dut.gen_cnt_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut.gen_cnt_q;
`endif
        run_gen(d);
        @(negedge clk); #1;
        n_tests++;
        if (gen_cnt !== 16'd0) begin n_fail++; $display("FAIL gen_cnt_wrap got %0d want 0", gen_cnt); end
    endtask

    initial begin
        test_reset();
        test_blinker();
        test_wall();
        test_reset_mid_gen();
        test_start_while_busy();
        test_back_to_back();
        test_gen_cnt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lfgm_row_seq.md
# lfgm_row_seq

Row sequencer and write-back controller for the lifegame engine. It owns the cell memory ports and drives the 5-bit phase code that the line generator consumes. For each row of one generation it reads the next grid row, steps the generator through its judge phases, and collects the 82-bit result. Each result is written back one row late, so no old-generation row is overwritten before the generator has finished with it.

## Interface
Parameters:
- ROWS, 60, grid rows. Memory rows 0..ROWS-1 hold cells; row ROWS is a permanent all-zero wall row that this block never writes.
- ADDR_W, 6, memory address width; must satisfy 2^ADDR_W > ROWS.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- start  in  1  single-cycle request to compute one generation; ignored while busy.
- busy  out  1  high from the first cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the final write-back.
- state  out  5  phase code to the line generator.
- wcf  out  1  judge enable to the generator.
- mem_rd  out  1  read strobe.
- mem_raddr  out  ADDR_W  read address.
- mem_wr  out  1  write strobe.
- mem_waddr  out  ADDR_W  write address.
- mem_wdata  out  108  write data, {26'd0, row[81:0]}.
- next_cell_dt  in  82  generator result; valid in the WRITE phase.
- gen_cnt  out  16  completed-generation count (see Configuration).

## Operation
- Phase codes: WAIT=17, PRE_READ_1=0, READ=1, SHIFTIN=5, CHK_UL..CHK_LR=6..13, JDG=14, DLT=15, WRITE=16.
- FSM:
  - WAIT, on start, goes to PRE_READ_1, which lasts 1 cycle. PRE_READ_1 sets mem_rd=1, mem_raddr=0 and row counter r=0.
  - Row loop for r=0..ROWS-1:
    - READ, 1 cycle: mem_rd=1, mem_raddr=r+1. For r=ROWS-1 this address is the wall row.
    - SHIFTIN, 2 cycles.
    - CHK_UL..CHK_LR, 1 cycle each, with wcf=1.
    - JDG, 1 cycle, then DLT, 1 cycle, then WRITE, 1 cycle.
  - WRITE:
    - Captures next_cell_dt into the pending register.
    - If r>=1, drives mem_wr=1, mem_waddr=r-1, mem_wdata={26'd0, old pending}.
    - Then r increments. If r was ROWS-1, go to FLUSH; otherwise go to READ.
  - FLUSH, 1 cycle: state output is WRITE; mem_wr=1, mem_waddr=ROWS-1 with the pending row.
  - FLUSH is followed by DONE, 1 cycle: done=1, state output is WAIT, then WAIT.
- Hazard rule: row r-1 is written only after row r+1 has been read, i.e. after the READ phase that uses address r+1.
- mem_rd and mem_wr are never high in the same cycle.
- wcf is 0 in all phases except CHK_*.

## Timing
- Memory read latency is fixed at 2 cycles: rd_data for an address is presented to the generator 2 cycles after its mem_rd cycle.
- Per-row cost is 14 cycles.
- Generation length:
  - start is sampled at cycle 0; PRE_READ_1 occurs at cycle 1.
  - FLUSH occurs at cycle 14·ROWS+2 and done at cycle 14·ROWS+3 (cycle 843 for ROWS=60).
  - busy falls in the cycle after done.
- Reset values:
  - state=WAIT (17); r=0; pending=0.
  - busy, done, wcf, mem_rd and mem_wr are 0; addresses are 0; mem_wdata is 0; gen_cnt is 0.
- start while busy or in DONE is dropped, with no queuing.
- start in the cycle after done is accepted normally.
- Reset mid-generation:
  - All outputs return to reset values on the next clock edge.
  - Memory may hold a partially updated grid. This is not recovered; the next start recomputes from memory contents.

## Configuration
- LFGM_SEQ_GEN_CNT_EN defined:
  - gen_cnt is a 16-bit register, incremented in the DONE cycle.
  - It wraps from 16'hFFFF to 0 and is cleared only by reset.
- LFGM_SEQ_GEN_CNT_EN undefined: gen_cnt is tied to 16'd0 and no counter logic is synthesized.

## Structure
- lfgm_pkg:
  - The 5-bit phase codes as a shared enum/localparams, also used by the line generator and the judge cells.
  - Constants: LFGM_ROW_W=82, LFGM_MEM_W=108, LFGM_RD_LAT=2.
- Sub-module lfgm_wb_buf:
  - Contains the pending 82-bit register plus the delayed write-address register.
  - Its interface is capture/flush strobes in, and wr/waddr/wdata out.
- FSM, row counter and dwell counter stay in the top module.

## Test plan
- Blinker:
  - Stimulus: row 10 = cells 20..22 set, ROWS=60, one start.
  - Required: after done, rows 9..11 have cell 21 set and no other cell is set.
  - Required: exactly 60 mem_wr pulses, with waddr sequence 0..59.
- Ordering and timing:
  - Stimulus: log all memory strobes during one generation.
  - Required: every mem_wr to address k occurs after the mem_rd of address k+2, or after the wall-row read when k=58 or k=59.
  - Required: done occurs at cycle 843.
- Wall row: all-zero grid, one start -> all writes carry 108'd0 and mem_waddr never equals 60.
- Start while busy: start pulsed at cycles 0 and 100 -> a single generation, a single done, and gen_cnt=1.
- Reset mid-generation: assert rst_n=0 at cycle 400 -> next cycle has state=17, busy=0 and mem_wr=0. A subsequent start runs a full 843-cycle generation.
- Counter wrap:
  - With LFGM_SEQ_GEN_CNT_EN and gen_cnt forced to 16'hFFFF -> one generation yields gen_cnt=0.
  - Without the macro, gen_cnt stays 0.
